// File: rtl/da_lut_loader.sv
// On-chip generator for the fir_filter distributed-arithmetic LUT: stores the tap
// coefficients, accumulates every bank/bit-pattern partial sum serially and streams it out.
module da_lut_loader #(
  parameter int NTAPS  = 64,
  parameter int GROUP  = 8,
  parameter int COEF_W = 16,
  parameter int LUT_W  = 19,
  parameter int ADDR_W = 11
) (
  input  logic                       clk_fast,
  input  logic                       reset,
  input  logic [COEF_W-1:0]          coef_in,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic                       coef_we,
  input  logic                       start,
  input  logic                       lut_ready,
  output logic [LUT_W-1:0]           CIN,
  output logic [ADDR_W-1:0]          CADDR,
  output logic                       CLOAD,
  output logic                       lut_valid,
  output logic                       busy,
  output logic                       done
);

  localparam int JW    = $clog2(GROUP);
  localparam int IDX_W = $clog2(NTAPS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [COEF_W-1:0]        coef_q [NTAPS];
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [LUT_W-1:0]         acc_q, acc_d;
  logic [JW-1:0]            j_q, j_d;
  logic [LUT_W-1:0]         cin_q, cin_d;
  logic [ADDR_W-1:0]        caddr_q, caddr_d;

  logic [GROUP-1:0]         pat;
  logic [IDX_W-1:0]         tap_idx;
  logic [COEF_W-1:0]        tap_coef;
  logic [LUT_W-1:0]         tap_term;
  logic [LUT_W-1:0]         acc_sum;

  // Upper address bits pick the bank, j picks the tap within it.
  assign pat      = addr_q[GROUP-1:0];
  assign tap_idx  = {addr_q[ADDR_W-1:GROUP], j_q};
  assign tap_coef = coef_q[tap_idx];
  assign tap_term = pat[j_q] ? {{(LUT_W-COEF_W){tap_coef[COEF_W-1]}}, tap_coef} : '0;
  assign acc_sum  = acc_q + tap_term;

  always_ff @(posedge clk_fast or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NTAPS; i++) begin
        coef_q[i] <= '0;
      end
    end else if (coef_we && (state_q == S_IDLE)) begin
      coef_q[coef_addr] <= coef_in;
    end
  end

  always_ff @(posedge clk_fast or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      acc_q   <= '0;
      j_q     <= '0;
      cin_q   <= '0;
      caddr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
      j_q     <= j_d;
      cin_q   <= cin_d;
      caddr_q <= caddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    acc_d   = acc_q;
    j_d     = j_q;
    cin_d   = cin_q;
    caddr_d = caddr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          addr_d  = '0;
          acc_d   = '0;
          j_d     = '0;
        end
      end
      S_ACCUM: begin
        acc_d = acc_sum;
        j_d   = j_q + 1'b1;
        // Output registers capture the finished sum on the last add.
        if (j_q == JW'(GROUP - 1)) begin
          state_d = S_PRESENT;
          cin_d   = acc_sum;
          caddr_d = addr_q;
        end
      end
      S_PRESENT: begin
        if (lut_ready) begin
          if (addr_q == '1) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ACCUM;
            addr_d  = addr_q + 1'b1;
            acc_d   = '0;
            j_d     = '0;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign CIN       = cin_q;
  assign CADDR     = caddr_q;
  assign lut_valid = (state_q == S_PRESENT);
  assign busy      = (state_q == S_ACCUM) || (state_q == S_PRESENT);
  assign CLOAD     = busy;
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_da_lut_loader.sv
// Bench for da_lut_loader: full and partial LUT runs compared entry by entry against a
// coefficient-array model of the partial sums, with random back-pressure.
module tb_da_lut_loader;

  logic        clk_fast = 1'b0;
  logic        reset;
  logic [15:0] coef_in;
  logic [5:0]  coef_addr;
  logic        coef_we;
  logic        start;
  logic        lut_ready;
  logic [18:0] CIN;
  logic [10:0] CADDR;
  logic        CLOAD;
  logic        lut_valid;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  logic signed [15:0] coef_m [64];
  logic [18:0]        obs [2048];

  da_lut_loader #(.NTAPS(64), .GROUP(8), .COEF_W(16), .LUT_W(19), .ADDR_W(11)) dut (
    .clk_fast (clk_fast),
    .reset    (reset),
    .coef_in  (coef_in),
    .coef_addr(coef_addr),
    .coef_we  (coef_we),
    .start    (start),
    .lut_ready(lut_ready),
    .CIN      (CIN),
    .CADDR    (CADDR),
    .CLOAD    (CLOAD),
    .lut_valid(lut_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk_fast = ~clk_fast;

  // Entry = sum of the bank's coefficients selected by the 8-bit pattern.
  function automatic logic [18:0] model_cin(input int a);
    int s;
    int bank;
    s = 0;
    bank = a / 256;
    for (int j = 0; j < 8; j++) begin
      if (((a % 256) >> j) % 2 == 1) s += int'(coef_m[bank * 8 + j]);
    end
    return 19'(s);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) coef_m[i] = '0;
  endtask

  task automatic load_coef(input int idx, input logic [15:0] v);
    @(negedge clk_fast);
    coef_we   = 1'b1;
    coef_addr = idx[5:0];
    coef_in   = v;
    coef_m[idx] = v;
  endtask

  task automatic kick(input bit with_we, input int idx, input logic [15:0] v);
    @(negedge clk_fast);
    start = 1'b1;
    coef_we = 1'b0;
    if (with_we) begin
      coef_we   = 1'b1;
      coef_addr = idx[5:0];
      coef_in   = v;
      coef_m[idx] = v;
    end
    @(posedge clk_fast);
  endtask

  task automatic check_quiet(input string tag);
    checks++;
    if ({CIN, CADDR, CLOAD, lut_valid, busy, done} !== '0) begin
      failures++;
      $display("FAIL %s: CIN=%h CADDR=%h CLOAD=%b valid=%b busy=%b done=%b, required all 0",
               tag, CIN, CADDR, CLOAD, lut_valid, busy, done);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk_fast);
    reset = 1'b1;
    @(posedge clk_fast);
    #1;
    check_quiet(tag);
    @(negedge clk_fast);
    reset = 1'b0;
    lut_ready = 1'b0;
    model_clear();
  endtask

  // Runs after a start edge. stop_addr<2047 leaves the run stalled at that entry.
  task automatic run_check(input string tag, input int stop_addr, input int stall_pct,
                           input bit poke, input bit timing, input int hold_addr);
    int exp_addr, cyc, first_valid, done_cyc, ndone, accept_cyc, hold_cnt, seen_hold;
    bit held_prev, finished;
    exp_addr = 0; cyc = 0; first_valid = -1; done_cyc = -1; ndone = 0;
    accept_cyc = -1; hold_cnt = 0; seen_hold = 0; held_prev = 1'b0; finished = 1'b0;
    while (cyc < 40000) begin
      @(negedge clk_fast);
      cyc++;
      start = 1'b0;
      coef_we = 1'b0;
      if (held_prev) begin
        checks++;
        if (lut_valid !== 1'b1) begin
          failures++;
          $display("FAIL %s_hold_valid: lut_valid=%b at cycle %0d, required 1", tag, lut_valid, cyc);
        end
      end
      held_prev = 1'b0;
      if (done) begin
        ndone++;
        done_cyc = cyc;
        checks++;
        if ({lut_valid, busy, CLOAD} !== 3'b000) begin
          failures++;
          $display("FAIL %s_done_outs: valid/busy/cload=%b, required 000", tag, {lut_valid, busy, CLOAD});
        end
      end
      if (lut_valid === 1'b1) begin
        if (first_valid < 0) first_valid = cyc;
        obs[exp_addr % 2048] = CIN;
        checks++;
        if (CADDR !== 11'(exp_addr) || CIN !== model_cin(exp_addr) || {busy, CLOAD} !== 2'b11) begin
          failures++;
          $display("FAIL %s_entry: CADDR=%h CIN=%h busy/cload=%b, required CADDR=%h CIN=%h 11",
                   tag, CADDR, CIN, {busy, CLOAD}, 11'(exp_addr), model_cin(exp_addr));
        end
        if (exp_addr == hold_addr) seen_hold++;
        if (exp_addr == stop_addr && stop_addr < 2047) begin
          lut_ready = 1'b0;
          finished = 1'b1;
          break;
        end
        lut_ready = ($urandom_range(99) >= 32'(stall_pct));
        if (exp_addr == hold_addr && hold_cnt < 5) begin
          lut_ready = 1'b0;
          hold_cnt++;
        end
        if (lut_ready) begin
          exp_addr++;
          if (exp_addr == 2048) accept_cyc = cyc;
        end else begin
          held_prev = 1'b1;
        end
      end else begin
        lut_ready = 1'($urandom_range(1));
        if (!done && exp_addr < 2048) begin
          checks++;
          if ({busy, CLOAD} !== 2'b11) begin
            failures++;
            $display("FAIL %s_busy: busy/cload=%b at cycle %0d, required 11", tag, {busy, CLOAD}, cyc);
          end
        end
      end
      if (accept_cyc > 0 && cyc == accept_cyc + 2) begin
        checks++;
        if ({busy, CLOAD, done, lut_valid} !== 4'b0000) begin
          failures++;
          $display("FAIL %s_idle_after: busy/cload/done/valid=%b, required 0000", tag,
                   {busy, CLOAD, done, lut_valid});
        end
        finished = 1'b1;
        break;
      end
      if (poke && cyc == 500) begin
        start = 1'b1;
        coef_we = 1'b1;
        coef_addr = 6'd0;
        coef_in = 16'd7;
      end
    end
    checks++;
    if (!finished) begin
      failures++;
      $display("FAIL %s_timeout: reached entry %0d after %0d cycles, required completion", tag, exp_addr, cyc);
    end
    if (stop_addr >= 2047) begin
      checks++;
      if (ndone != 1 || done_cyc != accept_cyc + 1) begin
        failures++;
        $display("FAIL %s_done: pulses=%0d at cycle %0d, required 1 at cycle %0d", tag, ndone, done_cyc, accept_cyc + 1);
      end
    end else begin
      checks++;
      if (ndone != 0) begin
        failures++;
        $display("FAIL %s_no_done: pulses=%0d, required 0", tag, ndone);
      end
    end
    if (timing) begin
      checks++;
      if (first_valid != 9 || done_cyc != 18433) begin
        failures++;
        $display("FAIL %s_latency: first valid cycle %0d done cycle %0d, required 9 and 18433", tag, first_valid, done_cyc);
      end
    end
    if (hold_addr >= 0) begin
      checks++;
      if (seen_hold != 6) begin
        failures++;
        $display("FAIL %s_hold_count: entry %0d shown %0d cycles, required 6", tag, hold_addr, seen_hold);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; coef_in = '0; coef_addr = '0; coef_we = 1'b0; start = 1'b0; lut_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk_fast);
    #1;
    check_quiet("reset");
    @(negedge clk_fast);
    reset = 1'b0;
    @(negedge clk_fast);
    check_quiet("idle_after_reset");
  endtask

  task automatic test_zero_run();
    kick(1'b0, 0, '0);
    run_check("zero", 2047, 0, 1'b0, 1'b1, -1);
  endtask

  task automatic test_ramp_stall();
    logic [18:0] want [6];
    int          at [6];
    for (int i = 0; i < 64; i++) load_coef(i, 16'(i + 1));
    kick(1'b0, 0, '0);
    run_check("ramp", 2047, 15, 1'b1, 1'b0, -1);
    at   = '{255, 511, 1793, 2047, 0, 3};
    want = '{19'd36, 19'd100, 19'd57, 19'd484, 19'd0, 19'd3};
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs[at[i]] !== want[i]) begin
        failures++;
        $display("FAIL ramp_spot: CADDR %h CIN=%h, required %h", 11'(at[i]), obs[at[i]], want[i]);
      end
    end
  endtask

  task automatic test_stall_and_reset();
    kick(1'b0, 0, '0);
    run_check("stall", 100, 0, 1'b0, 1'b0, 3);
    checks++;
    if (obs[1] !== 19'd1) begin
      failures++;
      $display("FAIL ignored_write: CADDR 001 CIN=%h, required 00001", obs[1]);
    end
    do_reset("midrun_reset");
    kick(1'b0, 0, '0);
    run_check("cleared", 300, 20, 1'b0, 1'b0, -1);
    do_reset("cleared_reset");
  endtask

  task automatic test_min_coef();
    for (int i = 1; i < 64; i++) load_coef(i, 16'h8000);
    kick(1'b1, 0, 16'h8000);
    run_check("mincoef", 256, 10, 1'b0, 1'b0, -1);
    checks++;
    if (obs[255] !== 19'h40000 || obs[1] !== 19'h78000) begin
      failures++;
      $display("FAIL mincoef_spot: CIN[0FF]=%h CIN[001]=%h, required 40000 78000", obs[255], obs[1]);
    end
    do_reset("mincoef_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 64; i++) load_coef(i, 16'($urandom));
    kick(1'b1, 5, 16'($urandom));
    run_check("random", 700, 30, 1'b0, 1'b0, -1);
    do_reset("random_reset");
  endtask

  initial begin
    test_reset();
    test_zero_run();
    test_ramp_stall();
    test_stall_and_reset();
    test_min_coef();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
